cv32e40p_cnn_bitplane_gen: RTL
==============================

CV32E40P_CNN_BITPLANE_GEN -- requirements
Module: cv32e40p_cnn_bitplane_gen

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port mode_i, input, 1; CNN mode enable; start_i ignored when 0.
REQ-004 SHALL have port start_i, input, 1; job request; accepted when start_i && ready_o && mode_i.
REQ-005 SHALL have port ready_o, output, 1; high only in IDLE.
REQ-006 SHALL have port act_i, input, [7:0] x 8b signed; eight input-activation taps, sampled on accept.
REQ-007 SHALL have port weight_i, input, [15:0][7:0] x 8b signed; per-channel tap weights, sampled on accept.
REQ-008 SHALL have port M_Cache_o, output, [7:0][15:0] x 16b signed; bit-plane partial sums, row b = plane b.
REQ-009 SHALL have port valid_o, output, 1; M_Cache_o complete, high only in DONE.
REQ-010 SHALL have port ack_i, input, 1; consumer has taken M_Cache_o.
REQ-011 SHALL have port busy_o, output, 1; high in RUN.

Function
REQ-012 SHALL implement FSM IDLE -> RUN (on accept) -> DONE (after plane 7 written) -> IDLE (on ack_i in DONE).
REQ-013 SHALL on accept register act_i and weight_i, clear all M_Cache_o rows to 0, and load plane counter to 0.
REQ-014 SHALL in each RUN cycle with counter b compute, for every channel i, psum = sum over taps k of (act[k][b] ? weight[i][k] : 0) and write it to M_Cache_o[b][i] at the clock edge.
REQ-015 SHALL sign-extend each 8b weight before summation; result range -1024..1016 held exactly in 16b signed; no saturation, no overflow possible.
REQ-016 SHALL use counter 0..7 without wrap; RUN lasts exactly 8 cycles; DONE entered at edge writing plane 7.
REQ-017 SHALL give latency: accept at edge N, valid_o high from cycle N+9 (1 capture + 8 planes).
REQ-018 SHALL hold M_Cache_o and valid_o stable in DONE until ack_i; ack_i outside DONE ignored.
REQ-019 SHALL ignore start_i while not IDLE; start_i concurrent with ack_i in DONE is not accepted (ready_o low); next accept earliest one cycle after return to IDLE.
REQ-020 SHALL on mode_i dropping to 0 in RUN or DONE abort to IDLE at next edge and clear M_Cache_o to 0.
REQ-021 SHALL keep plane 7 in M_Cache_o with positive partial sums (negative MSB weight is applied by the downstream combiner, not here).

Reset
REQ-022 SHALL on rst_n=0 at an edge force IDLE, counter 0, captured act/weight 0, M_Cache_o all 0, valid_o 0, busy_o 0, ready_o 1 after release.
REQ-023 SHALL let reset override any state mid-operation, discarding the in-flight job with no partial valid_o.

Structure
REQ-024 SHALL place in shared cnn package: NUM_TAPS=8, NUM_CH=16, ACT_W=8, PSUM_W=16, FSM state enum type.
REQ-025 SHALL use one sub-module cv32e40p_cnn_plane_mac (one channel: 8 taps x 1 bit -> 16b sum), instantiated 16 times.

Verification
REQ-026 SHALL test all act=8'h01, all weights=1: row0 every channel = 8, rows1..7 = 0, valid_o at N+9.
REQ-027 SHALL test act=8'hFF all taps, weights=-128: every row every channel = -1024; downstream combine gives -1024*(-1)= +1024 per channel.
REQ-028 SHALL test channel i weights=i, act tap k=8'h80 only tap 0: rows0..6=0, row7[i]=i.
REQ-029 SHALL test start_i asserted with ack_i in DONE: no new job; job accepted one cycle after ready_o rises.
REQ-030 SHALL test rst_n=0 at RUN cycle 4: next cycle IDLE, M_Cache_o all 0, valid_o never asserted.
REQ-031 SHALL test mode_i=0 with start_i=1 in IDLE: no accept, ready_o stays 1, outputs 0.

Source files
------------

// File: rtl/cv32e40p_cnn_bitplane_gen_pkg.sv
// Shared definitions for the CNN bit-plane partial-sum generator.
//   NUM_TAPS   : activation taps per job
//   NUM_CH     : output channels (one plane MAC each)
//   ACT_W      : activation / weight width, also the number of bit planes
//   PSUM_W     : partial-sum width per channel and plane
//   state_e    : job FSM state, also exported on the debug port
package cv32e40p_cnn_bitplane_gen_pkg;

  localparam int NUM_TAPS   = 8;
  localparam int NUM_CH     = 16;
  localparam int ACT_W      = 8;
  localparam int PSUM_W     = 16;
  localparam int NUM_PLANES = ACT_W;
  localparam int CNT_W      = $clog2(NUM_PLANES);

  localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(NUM_PLANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cv32e40p_cnn_plane_mac.sv
// One channel of one bit plane: adds the sign-extended weight of every tap
// whose activation bit is set in the current plane.
//   act_bits : one bit per tap, the selected plane of each activation
//   weights  : 8b signed weight per tap
//   psum     : 16b signed sum; 8 x [-128,127] always fits, no saturation
module cv32e40p_cnn_plane_mac
  import cv32e40p_cnn_bitplane_gen_pkg::*;
(
  input  logic [NUM_TAPS-1:0]            act_bits,
  input  logic [NUM_TAPS-1:0][ACT_W-1:0] weights,
  output logic [PSUM_W-1:0]              psum
);

  always_comb begin
    psum = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (act_bits[k]) begin
        psum = psum + {{(PSUM_W-ACT_W){weights[k][ACT_W-1]}}, weights[k]};
      end
    end
  end

endmodule

// File: rtl/cv32e40p_cnn_bitplane_gen.sv
// CNN bit-plane generator. A job captures eight activations and the per-channel
// tap weights, then spends one cycle per activation bit plane computing all
// sixteen channel sums for that plane into M_Cache_o[plane].
//   clk, rst_n   : clock, synchronous active-low reset
//   mode_i       : CNN mode; dropping it aborts a job and clears the cache
//   start_i      : job request, taken when start_i && ready_o && mode_i
//   ready_o      : high in IDLE only
//   act_i        : eight 8b activation taps
//   weight_i     : per channel, eight 8b tap weights
//   M_Cache_o    : 8 planes x 16 channels x 16b partial sums
//   valid_o      : cache complete (DONE); held until ack_i
//   ack_i        : consumer has taken the cache
//   busy_o       : high while planes are being computed
//   dbg_state    : current FSM state
//
// Handshakes: a job is accepted on the edge where start_i, mode_i and ready_o
// are all high; a result is released on the edge where valid_o and ack_i are
// both high. Plane 7 is stored as a positive sum; the downstream combiner
// applies the negative MSB weight.
module cv32e40p_cnn_bitplane_gen
  import cv32e40p_cnn_bitplane_gen_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         mode_i,
  input  logic                                         start_i,
  output logic                                         ready_o,
  input  logic [NUM_TAPS-1:0][ACT_W-1:0]               act_i,
  input  logic [NUM_CH-1:0][NUM_TAPS-1:0][ACT_W-1:0]   weight_i,
  output logic [NUM_PLANES-1:0][NUM_CH-1:0][PSUM_W-1:0] M_Cache_o,
  output logic                                         valid_o,
  input  logic                                         ack_i,
  output logic                                         busy_o,
  output state_e                                       dbg_state
);

  state_e                                       state_q, state_d;
  logic [CNT_W-1:0]                             cnt_q;
  logic [NUM_TAPS-1:0][ACT_W-1:0]               act_q;
  logic [NUM_CH-1:0][NUM_TAPS-1:0][ACT_W-1:0]   weight_q;
  logic [NUM_PLANES-1:0][NUM_CH-1:0][PSUM_W-1:0] cache_q;

  logic                          accept;
  logic                          abort;
  logic [NUM_TAPS-1:0]           plane_bits;
  logic [NUM_CH-1:0][PSUM_W-1:0] plane_psum;

  assign accept = start_i && mode_i && (state_q == ST_IDLE);
  // Leaving CNN mode mid-job throws the job away, including a finished one.
  assign abort  = !mode_i && (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (!mode_i)                  state_d = ST_IDLE;
        else if (cnt_q == LAST_PLANE) state_d = ST_DONE;
      end
      ST_DONE: if (!mode_i || ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit cnt_q of every captured activation selects which taps contribute.
  always_comb begin
    plane_bits = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      plane_bits[k] = act_q[k][cnt_q];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_mac
    cv32e40p_cnn_plane_mac u_mac (
      .act_bits (plane_bits),
      .weights  (weight_q[i]),
      .psum     (plane_psum[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      act_q    <= '0;
      weight_q <= '0;
      cache_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        act_q    <= act_i;
        weight_q <= weight_i;
        cnt_q    <= '0;
        cache_q  <= '0;
      end else if (abort) begin
        cnt_q   <= '0;
        cache_q <= '0;
      end else if (state_q == ST_RUN) begin
        cache_q[cnt_q] <= plane_psum;
        // Counter parks on the last plane; the next accept reloads it.
        if (cnt_q != LAST_PLANE) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign busy_o    = (state_q == ST_RUN);
  assign valid_o   = (state_q == ST_DONE);
  assign M_Cache_o = cache_q;
  assign dbg_state = state_q;

endmodule
